// File: rtl/hes_pkg.sv
// Shared types and default sizing for the HES cipher feeder.
package hes_pkg;

   localparam int unsigned HES_DEPTH   = 16;
   localparam int unsigned HES_MAX_LEN = 255;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      STREAM
   } framer_state_e;

   typedef struct packed {
      logic  last;
      byte_t data;
   } fifo_entry_t;

endpackage

// File: rtl/hes_byte_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags and occupancy count.
module hes_byte_fifo
   import hes_pkg::*;
#(
   parameter int unsigned DEPTH = HES_DEPTH,
   parameter type entry_t = fifo_entry_t
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  entry_t                   wdata_i,
   input  logic                     pop_i,
   output entry_t                   rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   entry_t         mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q, count_d;
   logic           push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once count says they are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/hes_msg_framer.sv
// Frames buffered host bytes into messages for the HES cipher core.
// Optional HES_FRAMER_STATS_EN adds a 16-bit completed-message counter output.
//
// state  | meaning
// IDLE   | waiting for a buffered byte; latches message key on exit
// START  | one cycle, no pop; new_message registers on the way out
// STREAM | pops one byte per non-empty cycle until last or MAX_LEN
module hes_msg_framer
   import hes_pkg::*;
#(
   parameter int unsigned DEPTH   = HES_DEPTH,
   parameter int unsigned MAX_LEN = HES_MAX_LEN
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   s_valid,
   output logic   s_ready,
   input  byte_t  s_data,
   input  logic   s_last,
   input  byte_t  key_in,
   input  logic   key_load,
   output logic   new_message,
   output logic   valid_out,
   output byte_t  data_out,
   output byte_t  key_out,
   output logic   busy,
   output logic   len_err
`ifdef HES_FRAMER_STATS_EN
   ,
   output logic [15:0] msg_count
`endif
);

   localparam int unsigned CNTW = $clog2(MAX_LEN + 1);

   framer_state_e            state_q, state_d;
   logic [CNTW-1:0]          cnt_q, cnt_d;
   byte_t                    shadow_q, shadow_d;
   byte_t                    key_out_q, key_out_d;
   byte_t                    data_out_q, data_out_d;
   logic                     new_message_q, new_message_d;
   logic                     valid_out_q, valid_out_d;
   logic                     busy_q, busy_d;
   logic                     len_err_q, len_err_d;
   logic                     pop, final_pop;

   fifo_entry_t              push_entry, rdata;
   logic                     fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0]   fifo_count_unused;

   assign s_ready    = !fifo_full && !reset_n;
   assign push_entry = '{last: s_last, data: s_data};

   hes_byte_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fifo_entry_t)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (s_valid && s_ready),
      .wdata_i (push_entry),
      .pop_i   (pop),
      .rdata_o (rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count_unused)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      shadow_d      = key_load ? key_in : shadow_q;
      key_out_d     = key_out_q;
      data_out_d    = data_out_q;
      new_message_d = 1'b0;
      valid_out_d   = 1'b0;
      len_err_d     = 1'b0;
      pop           = 1'b0;
      final_pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d   = START;
               key_out_d = shadow_d;   // shadow_d carries a coincident key_load through
            end
         end
         START: begin
            new_message_d = 1'b1;
            cnt_d         = '0;
            state_d       = STREAM;
         end
         STREAM: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               valid_out_d = 1'b1;
               data_out_d  = rdata.data;
               cnt_d       = cnt_q + CNTW'(1);
               if (rdata.last || (cnt_q == CNTW'(MAX_LEN - 1))) begin
                  final_pop = 1'b1;
                  len_err_d = !rdata.last;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) || final_pop;
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         shadow_q      <= '0;
         key_out_q     <= '0;
         data_out_q    <= '0;
         new_message_q <= 1'b0;
         valid_out_q   <= 1'b0;
         busy_q        <= 1'b0;
         len_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shadow_q      <= shadow_d;
         key_out_q     <= key_out_d;
         data_out_q    <= data_out_d;
         new_message_q <= new_message_d;
         valid_out_q   <= valid_out_d;
         busy_q        <= busy_d;
         len_err_q     <= len_err_d;
      end
   end

   assign new_message = new_message_q;
   assign valid_out   = valid_out_q;
   assign data_out    = data_out_q;
   assign key_out     = key_out_q;
   assign busy        = busy_q;
   assign len_err     = len_err_q;

`ifdef HES_FRAMER_STATS_EN
   logic [15:0] msg_count_q;

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n)        msg_count_q <= '0;
      else if (final_pop) msg_count_q <= msg_count_q + 16'd1;
   end

   assign msg_count = msg_count_q;
`endif

endmodule

// File: tb/tb_hes_msg_framer.sv
// Directed + random bench for hes_msg_framer against a message-level scoreboard.
module tb_hes_msg_framer;

   localparam int DEPTH   = 16;
   localparam int MAX_LEN = 12;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       s_valid, s_ready, s_last, key_load;
   logic [7:0] s_data, key_in;
   logic       new_message, valid_out, busy, len_err;
   logic [7:0] data_out, key_out;
`ifdef HES_FRAMER_STATS_EN
   logic [15:0] msg_count;
`endif

   always #5 clk = ~clk;

   hes_msg_framer #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .key_in      (key_in),
      .key_load    (key_load),
      .new_message (new_message),
      .valid_out   (valid_out),
      .data_out    (data_out),
      .key_out     (key_out),
      .busy        (busy),
      .len_err     (len_err)
`ifdef HES_FRAMER_STATS_EN
      ,
      .msg_count   (msg_count)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Reference model: accepted bytes in order, split into messages by last/MAX_LEN.
   typedef struct {
      logic       last;
      logic [7:0] data;
   } ent_t;
   ent_t       exp_q[$];
   ent_t       e_m;
   int         in_msg = 0;
   int         msg_cnt_m = 0;
   logic       nm_prev = 1'b0;
   logic [7:0] sh_cur = 8'h00, sh_prev = 8'h00, msg_key = 8'h00, last_data = 8'h00;
   int         vo_count = 0, nm_count = 0, le_count = 0, run = 0, last_run = 0;
   logic       saw_full = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (s_ready !== 1'b1 && n < 500) begin
         tick();
         n++;
      end
      chk("send_timeout", n < 500, 1);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
         tick();
         n++;
      end
      chk("drain_timeout", n < 2000, 1);
      tick();
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         exp_q.delete();
         in_msg    = 0;
         msg_cnt_m = 0;
         nm_prev   = 1'b0;
         sh_cur    = 8'h00;
         sh_prev   = 8'h00;
         msg_key   = 8'h00;
         last_data = 8'h00;
         run       = 0;
      end else begin
         if (new_message) begin
            chk("nm_at_boundary", in_msg, 0);
            chk("key_at_start", key_out, sh_prev);
            msg_key = sh_prev;
            nm_count++;
         end
         if (valid_out) begin
            chk("byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e_m = exp_q.pop_front();
               in_msg++;
               chk("data_out", data_out, e_m.data);
               chk("first_after_nm", nm_prev, in_msg == 1);
               chk("key_stable", key_out, msg_key);
               chk("len_err", len_err, !e_m.last && in_msg == MAX_LEN);
               chk("busy_stream", busy, 1);
               last_data = e_m.data;
               if (e_m.last || in_msg == MAX_LEN) begin
                  in_msg = 0;
                  msg_cnt_m++;
               end
            end
            vo_count++;
            run++;
         end else begin
            chk("len_err_idle", len_err, 0);
            chk("data_hold", data_out, last_data);
            if (run > 0) last_run = run;
            run = 0;
         end
         chk("nm_vo_overlap", new_message && valid_out, 0);
         chk("s_ready", s_ready, exp_q.size() < DEPTH);
`ifdef HES_FRAMER_STATS_EN
         chk("msg_count", msg_count, msg_cnt_m & 32'h0000_FFFF);
`endif
         if (len_err) le_count++;
         if (!s_ready) saw_full = 1'b1;
         if (s_valid && s_ready) exp_q.push_back('{last: s_last, data: s_data});
         nm_prev = new_message;
         sh_prev = sh_cur;
         if (key_load) sh_cur = key_in;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_nm, base_vo, base_le, n;
      s_valid  = 1'b0;
      s_data   = 8'h00;
      s_last   = 1'b0;
      key_in   = 8'h00;
      key_load = 1'b0;

      #3;
      chk("rst_new_message", new_message, 0);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_key_out", key_out, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_s_ready", s_ready, 0);
      repeat (3) tick();
      reset_n = 1'b0;
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_s_ready", s_ready, 1);

      // Basic framing with key 0x11
      key_in = 8'h11; key_load = 1'b1; tick(); key_load = 1'b0;
      base_nm = nm_count; base_vo = vo_count;
      for (int i = 0; i < 10; i++) send(8'(i), i == 9);
      drain();
      chk("basic_vo", vo_count - base_vo, 10);
      chk("basic_run", last_run, 10);
      chk("basic_nm", nm_count - base_nm, 1);
      chk("basic_key", key_out, 8'h11);
      chk("basic_busy", busy, 0);

      // Bubbles: output pattern 1,0,0,1,1
      base_nm = nm_count;
      s_valid = 1'b1; s_data = 8'hA0; s_last = 1'b0;
      tick();
      s_valid = 1'b0;
      n = 0;
      while (valid_out !== 1'b1 && n < 20) begin tick(); n++; end
      chk("bub_wait", n < 20, 1);
      chk("bub_p0", valid_out, 1);
      tick(); chk("bub_p1", valid_out, 0); s_valid = 1'b1; s_data = 8'hA1;
      tick(); chk("bub_p2", valid_out, 0); s_data = 8'hA2; s_last = 1'b1;
      tick(); chk("bub_p3", valid_out, 1); s_valid = 1'b0; s_last = 1'b0;
      tick(); chk("bub_p4", valid_out, 1);
      tick(); chk("bub_end", valid_out, 0);
      chk("bub_busy", busy, 0);
      chk("bub_nm", nm_count - base_nm, 1);

      // Full FIFO: single-byte messages drain slower than the host fills
      base_vo = vo_count; saw_full = 1'b0;
      for (int i = 0; i < 30; i++) send(8'h40 + 8'(i), 1'b1);
      drain();
      chk("full_seen", saw_full, 1);
      chk("full_vo", vo_count - base_vo, 30);

      // Key isolation: 0x22 loaded mid-message
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin key_in = 8'h22; key_load = 1'b1; end
         send(8'h50 + 8'(i), i == 7);
         key_load = 1'b0;
      end
      drain();
      chk("keyiso_hold", key_out, 8'h11);
      send(8'h58, 1'b0); send(8'h59, 1'b1);
      drain();
      chk("keyiso_new", key_out, 8'h22);

      // MAX_LEN termination: 14 bytes split as 12 + 2
      base_nm = nm_count; base_vo = vo_count; base_le = le_count;
      for (int i = 0; i < 14; i++) send(8'h60 + 8'(i), i == 13);
      drain();
      chk("ml_nm", nm_count - base_nm, 2);
      chk("ml_le", le_count - base_le, 1);
      chk("ml_vo", vo_count - base_vo, 14);

      // Reset mid-message
      base_vo = vo_count;
      for (int i = 0; i < 7; i++) send(8'h80 + 8'(i), 1'b0);
      n = 0;
      while (vo_count - base_vo < 5 && n < 50) begin tick(); n++; end
      chk("rst_mid_wait", n < 50, 1);
      #2 reset_n = 1'b1;
      #1;
      chk("arst_valid_out", valid_out, 0);
      chk("arst_new_message", new_message, 0);
      chk("arst_data_out", data_out, 8'h00);
      chk("arst_key_out", key_out, 8'h00);
      chk("arst_busy", busy, 0);
      chk("arst_len_err", len_err, 0);
      chk("arst_s_ready", s_ready, 0);
      tick(); tick();
      reset_n = 1'b0;
      base_nm = nm_count;
      repeat (5) tick();
      chk("post_rst_no_nm", nm_count - base_nm, 0);
      chk("post_rst_busy", busy, 0);
      base_vo = vo_count;
      send(8'h90, 1'b0); send(8'h91, 1'b1);
      drain();
      chk("post_rst_nm", nm_count - base_nm, 1);
      chk("post_rst_vo", vo_count - base_vo, 2);
      chk("post_rst_key", key_out, 8'h00);

      // Random messages, gaps and key loads
      for (int m = 0; m < 40; m++) begin
         int len;
         len = int'($urandom_range(1, 16));
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            if ($urandom_range(0, 9) == 0) begin
               key_in   = 8'($urandom);
               key_load = 1'b1;
            end
            send(8'($urandom), b == len - 1);
            key_load = 1'b0;
         end
      end
      drain();
      chk("rand_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hes_msg_framer.md
Name: hes_msg_framer

Overview:
Upstream feeder for the HES byte-stream AES cipher core. Accepts host bytes over a valid/ready handshake and buffers them in a small FIFO. Frames each message for the cipher: a one-cycle new_message pulse, then one valid_out strobe per byte. Holds the message key stable from the start-of-message pulse to the last byte.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, at least 4.
MAX_LEN, 255, maximum bytes per message; longer messages are force-terminated.

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  reset, asynchronous, active-high (asserted when reset_n=1)
s_valid  in  1  host byte valid
s_ready  out  1  framer can accept a byte
s_data  in  8  host byte
s_last  in  1  marks final byte of a message
key_in  in  8  host key value
key_load  in  1  capture key_in into shadow key register
new_message  out  1  one-cycle start-of-message pulse to cipher
valid_out  out  1  data_out valid to cipher
data_out  out  8  byte to cipher
key_out  out  8  key presented to cipher
busy  out  1  high from START until the last byte is issued
len_err  out  1  one-cycle pulse when a message is force-terminated at MAX_LEN

Behaviour:
- Reset values: new_message=0, valid_out=0, data_out=0x00, key_out=0x00, shadow key=0x00, busy=0, len_err=0, FIFO empty, byte counter 0, state IDLE. s_ready=0 while reset is asserted.
- All outputs to the cipher are registered. The cipher has no backpressure, so the framer never waits on it.
- Push: the FIFO stores {s_last, s_data} when s_valid&&s_ready. s_ready = !full. A push and a pop in the same cycle are both legal, and the occupancy count stays unchanged.
- Key: key_load writes key_in to the shadow register at any time. key_out is loaded from the shadow register only on the IDLE->START transition. A key_load during a message takes effect at the next message. If key_load coincides with IDLE->START, key_out takes the new key_in value (bypass).
- FSM IDLE: the framer waits for the FIFO to be non-empty, then moves to START.
- FSM START: the framer drives new_message=1 for exactly one cycle, sets busy=1, clears the byte counter and moves to STREAM. No pop occurs in this cycle.
- FSM STREAM: each cycle with the FIFO non-empty pops one entry and drives valid_out=1 and data_out=byte on the next edge. The byte counter increments on each pop. If the FIFO is empty, valid_out=0 for that cycle (a bubble) and the state holds.
- STREAM exit: the popped entry has last=1, or the counter reaches MAX_LEN. The FSM then returns to IDLE and busy deasserts after the final valid_out cycle.
- MAX_LEN termination: len_err pulses with the final byte. Remaining bytes up to s_last form the next message, which gets its own new_message.
- Timing: the first valid_out follows new_message by exactly 1 cycle when data is present. Back-to-back messages are separated by at least IDLE+START, i.e. new_message is never asserted while valid_out=1 in the same cycle.
- data_out holds its last value when valid_out=0.
- Reset mid-message: all state clears immediately and buffered bytes are discarded. No new_message is issued until new data arrives after reset deassertion.

Optional Feature:
HES_FRAMER_STATS_EN:
- Defined: adds output msg_count[15:0], which increments when each message's final byte is issued (including MAX_LEN terminations), wraps 0xFFFF->0x0000, and resets to 0.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package hes_pkg holds: byte_t (logic[7:0]), the framer state enum {IDLE, START, STREAM}, the fifo_entry_t struct {last, data}, and the default DEPTH/MAX_LEN constants.
- Sub-module hes_byte_fifo is a synchronous FIFO with full/empty flags and a count, parameterised by DEPTH and entry type. The FSM, key shadow and counters stay in hes_msg_framer.

Test Plan:
- Basic framing: key_load with key_in=0x11, then push 10 bytes 0x00..0x09 with s_last on 0x09 -> new_message one cycle, key_out=0x11, then 10 consecutive valid_out cycles carrying 0x00..0x09, busy low afterwards.
- Bubbles: push 3 bytes with a 2-cycle host gap after byte 1 -> valid_out pattern 1,0,0,1,1 with no extra new_message.
- Full FIFO: hold s_valid with 20 bytes and DEPTH=16 -> s_ready drops only at 16 occupancy, no byte lost or duplicated, output order preserved.
- Key isolation: key_load 0x22 mid-message after key 0x11 -> key_out stays 0x11 until the next new_message, then becomes 0x22.
- MAX_LEN=4, message of 6 bytes -> len_err with byte 4, second new_message, remaining 2 bytes follow; with HES_FRAMER_STATS_EN, msg_count=2.
- Reset asserted during byte 5 of 10 -> outputs clear asynchronously, FIFO empty, and after release a fresh 2-byte message frames correctly.
